// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stalls, branch-redirect flushes and memory-wait freezes.
// Control outputs are combinational from state and inputs; state, counters and the timeout flag are registered.
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_RegDest,
    input  logic             ex_PCSrc,
    input  logic [31:0]      ex_BranchTarget,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_freeze,
    output logic             pc_redirect,
    output logic [31:0]      redirect_target,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int unsigned FCNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);
    localparam int unsigned WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [FCNT_W-1:0] FCNT_INIT  = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    state_t            ret_state, ret_state_nxt;
    logic [FCNT_W-1:0] fcnt, fcnt_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic              busy;
    logic              load_use;
    logic              timeout_hit;

    assign redirect_target = ex_BranchTarget;

    assign busy     = mem_req & ~mem_ready;
    assign load_use = ex_MemRead && (ex_RegDest != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_RegDest)) ||
                       (id_use_rs2 && (id_rs2 == ex_RegDest)));

    assign timeout_hit = (MEM_TIMEOUT != 0) && (state == MEM_WAIT) && (wcnt == WCNT_LIMIT);

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        pipe_freeze   = 1'b0;
        pc_redirect   = 1'b0;
        state_nxt     = state;
        ret_state_nxt = ret_state;
        fcnt_nxt      = fcnt;
        wcnt_nxt      = wcnt;

        if (rst) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            unique case (state)
                MEM_WAIT: begin
                    if (wcnt != '1) begin
                        wcnt_nxt = wcnt + WCNT_W'(1);
                    end
                    if (mem_ready) begin
                        state_nxt = ret_state;
                    end else begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        pipe_freeze = 1'b1;
                    end
                end
                default: begin
                    if (busy) begin
                        // Freeze wins outright; the branch/load stay in place and are re-seen on exit.
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        pipe_freeze   = 1'b1;
                        ret_state_nxt = state;
                        state_nxt     = MEM_WAIT;
                        wcnt_nxt      = WCNT_W'(1);
                    end else if (ex_PCSrc && (state != FLUSH)) begin
                        pc_redirect = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_nxt = FLUSH;
                            fcnt_nxt  = FCNT_INIT;
                        end else begin
                            state_nxt = RUN;
                        end
                    end else begin
                        if (load_use) begin
                            pc_write    = 1'b0;
                            if_id_write = 1'b0;
                            id_ex_flush = 1'b1;
                        end
                        // A load-use bubble inside the flush window still consumes a flush cycle.
                        if (state == FLUSH) begin
                            fcnt_nxt = fcnt - FCNT_W'(1);
                            if (fcnt <= FCNT_W'(1)) begin
                                state_nxt = RUN;
                            end
                        end else begin
                            state_nxt = load_use ? LOAD_STALL : RUN;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            ret_state   <= RUN;
            fcnt        <= '0;
            wcnt        <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_state_nxt;
            fcnt      <= fcnt_nxt;
            wcnt      <= wcnt_nxt;
            if (timeout_hit) begin
                mem_timeout <= 1'b1;
            end
            if (!pc_write && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (pc_redirect && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Table-driven bench for hazard_ctrl with a scoreboard queue and a bench-side counter model.
module tb_hazard_ctrl;
    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_RegDest;
    logic        id_use_rs1, id_use_rs2, ex_MemRead, ex_PCSrc, mem_req, mem_ready;
    logic [31:0] ex_BranchTarget;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, pc_redirect;
    logic [31:0] redirect_target;
    logic        mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(3), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_MemRead(ex_MemRead), .ex_RegDest(ex_RegDest), .ex_PCSrc(ex_PCSrc),
        .ex_BranchTarget(ex_BranchTarget), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .pipe_freeze(pipe_freeze), .pc_redirect(pc_redirect),
        .redirect_target(redirect_target), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Expected control bundle: {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, pc_redirect}
    localparam logic [5:0] E_DEF = 6'b110000;
    localparam logic [5:0] E_RST = 6'b001100;
    localparam logic [5:0] E_LU  = 6'b000100;
    localparam logic [5:0] E_RD  = 6'b111101;
    localparam logic [5:0] E_FRZ = 6'b000010;

    typedef struct {
        string       nm;
        logic        r;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic        mr;
        logic [4:0]  rd;
        logic        pcs;
        logic [31:0] tgt;
        logic        req;
        logic        rdy;
        logic [5:0]  exp;
        logic        to;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_stall = 0;
    int   m_flush = 0;
    localparam int CMAX = (1 << CW) - 1;

    function automatic vec_t mk(string nm, logic r, logic [4:0] rs1, logic u1, logic [4:0] rs2,
                                logic u2, logic mr, logic [4:0] rd, logic pcs, logic [31:0] tgt,
                                logic req, logic rdy, logic [5:0] exp, logic to);
        vec_t v;
        v.nm = nm; v.r = r; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.mr = mr;
        v.rd = rd; v.pcs = pcs; v.tgt = tgt; v.req = req; v.rdy = rdy; v.exp = exp; v.to = to;
        return v;
    endfunction

    task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s.%s: got 0x%0h want 0x%0h", nm, what, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.r; id_rs1 = v.rs1; id_use_rs1 = v.u1; id_rs2 = v.rs2; id_use_rs2 = v.u2;
        ex_MemRead = v.mr; ex_RegDest = v.rd; ex_PCSrc = v.pcs; ex_BranchTarget = v.tgt;
        mem_req = v.req; mem_ready = v.rdy;
        sb.push_back(v);
    endtask

    task automatic sample();
        vec_t e;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: empty queue at %0t", $time);
            return;
        end
        e = sb.pop_front();
        n_vec++;
        if (e.r) begin
            m_stall = 0;
            m_flush = 0;
        end
        chk(e.nm, "ctrl", 32'({pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, pc_redirect}),
            32'(e.exp));
        chk(e.nm, "redirect_target", redirect_target, e.tgt);
        chk(e.nm, "mem_timeout", 32'(mem_timeout), 32'(e.to));
        chk(e.nm, "stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk(e.nm, "flush_cnt", 32'(flush_cnt), 32'(m_flush));
        if (!e.r) begin
            if (!e.exp[5] && m_stall < CMAX) m_stall++;
            if (e.exp[0] && m_flush < CMAX) m_flush++;
        end
    endtask

    task automatic apply(input vec_t v);
        @(posedge clk);
        #1 drive(v);
        @(negedge clk);
        sample();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_MemRead = 1'b0; ex_RegDest = '0; ex_PCSrc = 1'b0; ex_BranchTarget = '0;
        mem_req = 1'b0; mem_ready = 1'b0;

        //              name           r  rs1 u1 rs2 u2 mr rd  pcs tgt          req rdy exp    to
        tbl.push_back(mk("rst0",        1, 0, 0, 0, 0, 0, 0,  0, 32'h0,      0, 0, E_RST, 0));
        tbl.push_back(mk("rst1",        1, 0, 0, 0, 0, 0, 0,  0, 32'h0,      0, 0, E_RST, 0));
        tbl.push_back(mk("idle",        0, 0, 0, 0, 0, 0, 0,  0, 32'h0,      0, 0, E_DEF, 0));
        tbl.push_back(mk("lu_rs1",      0, 5, 1, 0, 0, 1, 5,  0, 32'h0,      0, 0, E_LU,  0));
        tbl.push_back(mk("after_lu",    0, 5, 1, 0, 0, 0, 0,  0, 32'h0,      0, 0, E_DEF, 0));
        tbl.push_back(mk("rd_x0",       0, 0, 1, 0, 0, 1, 0,  0, 32'h0,      0, 0, E_DEF, 0));
        tbl.push_back(mk("rs2_unused",  0, 3, 1, 7, 0, 1, 7,  0, 32'h0,      0, 0, E_DEF, 0));
        tbl.push_back(mk("lu_rs2",      0, 3, 1, 7, 1, 1, 7,  0, 32'h0,      0, 0, E_LU,  0));
        tbl.push_back(mk("after_lu2",   0, 0, 0, 0, 0, 0, 0,  0, 32'h0,      0, 0, E_DEF, 0));
        tbl.push_back(mk("redir",       0, 0, 0, 0, 0, 0, 0,  1, 32'h40,     0, 0, E_RD,  0));
        tbl.push_back(mk("redir_mask",  0, 0, 0, 0, 0, 0, 0,  1, 32'h80,     0, 0, E_DEF, 0));
        tbl.push_back(mk("idle2",       0, 0, 0, 0, 0, 0, 0,  0, 32'h0,      0, 0, E_DEF, 0));
        tbl.push_back(mk("redir2",      0, 0, 0, 0, 0, 0, 0,  1, 32'h100,    0, 0, E_RD,  0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk("flush_busy", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,  1, 0, E_FRZ, 0));
        tbl.push_back(mk("flush_busy5", 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,      1, 0, E_FRZ, 1));
        tbl.push_back(mk("flush_rdy",   0, 0, 0, 0, 0, 0, 0,  0, 32'h0,      1, 1, E_DEF, 1));
        tbl.push_back(mk("flush_resume",0, 0, 0, 0, 0, 0, 0,  1, 32'h200,    0, 0, E_DEF, 1));
        tbl.push_back(mk("run_redir",   0, 0, 0, 0, 0, 0, 0,  1, 32'h300,    0, 0, E_RD,  1));
        tbl.push_back(mk("flush_idle",  0, 0, 0, 0, 0, 0, 0,  0, 32'h0,      0, 0, E_DEF, 1));
        tbl.push_back(mk("redir4",      0, 0, 0, 0, 0, 0, 0,  1, 32'h500,    0, 0, E_RD,  1));
        tbl.push_back(mk("flush_lu",    0, 9, 1, 0, 0, 1, 9,  0, 32'h0,      0, 0, E_LU,  1));
        tbl.push_back(mk("idle3",       0, 0, 0, 0, 0, 0, 0,  0, 32'h0,      0, 0, E_DEF, 1));
        tbl.push_back(mk("busy_all",    0, 9, 1, 0, 0, 1, 9,  1, 32'h600,    1, 0, E_FRZ, 1));
        tbl.push_back(mk("busy_all2",   0, 9, 1, 0, 0, 1, 9,  1, 32'h600,    1, 0, E_FRZ, 1));
        tbl.push_back(mk("wait_done",   0, 9, 1, 0, 0, 1, 9,  1, 32'h600,    1, 1, E_DEF, 1));
        tbl.push_back(mk("redir_after", 0, 9, 1, 0, 0, 1, 9,  1, 32'h600,    0, 0, E_RD,  1));
        tbl.push_back(mk("flush_idle2", 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,      0, 0, E_DEF, 1));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk("sat_busy",  0, 0, 0, 0, 0, 0, 0, 0, 32'h0,  1, 0, E_FRZ, 1));
        tbl.push_back(mk("sat_rdy",     0, 0, 0, 0, 0, 0, 0,  0, 32'h0,      0, 1, E_DEF, 1));
        tbl.push_back(mk("sat_idle",    0, 0, 0, 0, 0, 0, 0,  0, 32'h0,      0, 0, E_DEF, 1));
        for (int i = 0; i < 12; i++) begin
            tbl.push_back(mk("fsat_redir", 0, 0, 0, 0, 0, 0, 0, 1, 32'h1000 + 32'(i), 0, 0, E_RD, 1));
            tbl.push_back(mk("fsat_idle",  0, 0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0, E_DEF, 1));
        end
        tbl.push_back(mk("fsat_check",  0, 0, 0, 0, 0, 0, 0,  0, 32'h0,      0, 0, E_DEF, 1));

        foreach (tbl[i]) apply(tbl[i]);

        // Reset asserted between edges while in LOAD_STALL
        apply(mk("lu_pre_rst",  0, 5, 1, 0, 0, 1, 5, 0, 32'h0, 0, 0, E_LU, 1));
        @(posedge clk);
        #3 drive(mk("rst_mid_ls", 1, 5, 1, 0, 0, 1, 5, 0, 32'h0, 0, 0, E_RST, 0));
        #1 sample();
        apply(mk("rst_hold",    1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, E_RST, 0));
        apply(mk("rst_rel",     0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, E_DEF, 0));

        // Reset asserted between edges while in MEM_WAIT; idle after release must not freeze
        apply(mk("wait_pre1",   0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, E_FRZ, 0));
        apply(mk("wait_pre2",   0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, E_FRZ, 0));
        @(posedge clk);
        #3 drive(mk("rst_mid_mw", 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, E_RST, 0));
        #1 sample();
        apply(mk("rst_hold2",   1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, E_RST, 0));
        apply(mk("rst_rel2",    0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, E_DEF, 0));
        apply(mk("run_redir2",  0, 0, 0, 0, 0, 0, 0, 1, 32'h40, 0, 0, E_RD, 0));
        apply(mk("final_idle",  0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, E_DEF, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
